// File: rtl/magnetron_pkg.sv
// ============================================================================
// magnetron_pkg : shared state encoding and default sizing for magnetron_ctrl
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package magnetron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int c_POWER_W   = 3;
  localparam int c_GUARD_CYC = 4;

endpackage

`default_nettype wire

// File: rtl/magnetron_ctrl_pwm.sv
// ============================================================================
// mag_pwm : PWM counter, duty compare and optional soft-start ramp (SOFT_START_EN)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mag_pwm
  import magnetron_pkg::*;
#(
  parameter int POWER_W = c_POWER_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               hold,
  input  logic               load,
  input  logic               tick_en,
  input  logic [POWER_W-1:0] power_q,
  output logic               mag_q
);

  logic [POWER_W-1:0] r_cnt;
  logic [POWER_W-1:0] w_cnt_nxt;
  logic [POWER_W-1:0] w_power_eff;
  logic               r_mag_q;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (load)
      w_cnt_nxt = '0;
    else if (!hold && tick_en)
      w_cnt_nxt = r_cnt + 1'b1;
  end

`ifdef SOFT_START_EN
  // MSB of the ramp set means one full period has elapsed since COOK entry
  logic [POWER_W:0] r_ramp;
  logic [POWER_W:0] w_ramp_nxt;

  always_comb begin
    w_ramp_nxt = r_ramp;
    if (!run)
      w_ramp_nxt = '0;
    else if (!hold && tick_en && !r_ramp[POWER_W])
      w_ramp_nxt = r_ramp + 1'b1;
    w_power_eff = w_ramp_nxt[POWER_W] ? power_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ramp <= '0;
    else
      r_ramp <= w_ramp_nxt;
  end
`else
  assign w_power_eff = power_q;
`endif

  // Compare against the next count so mag_q lines up with the count it reflects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_mag_q <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_mag_q <= run && (w_cnt_nxt <= w_power_eff);
    end
  end

  assign mag_q = r_mag_q;

endmodule

`default_nettype wire

// File: rtl/magnetron_ctrl.sv
// ============================================================================
// magnetron_ctrl : cooking-cycle FSM with interlock, restart guard and PWM power
// Optional soft-start ramp enabled by macro SOFT_START_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module magnetron_ctrl
  import magnetron_pkg::*;
#(
  parameter int POWER_W   = c_POWER_W,
  parameter int GUARD_CYC = c_GUARD_CYC,
  parameter int GUARD_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               door_closed,
  input  logic               timer_done,
  input  logic               tick_en,
  input  logic [POWER_W-1:0] power_level,
  output logic               mag_on,
  output logic               sr_set,
  output logic               sr_rst,
  output logic               cook_done,
  output logic [1:0]         state_o
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [GUARD_W-1:0] r_guard;
  logic [POWER_W-1:0] r_power_q;
  logic [POWER_W-1:0] w_power_sel;
  logic               w_start_ok;
  logic               w_load;
  logic               w_mag_q;
  logic               r_mag_prev;
  logic               r_sr_set;
  logic               r_sr_rst;

  assign w_start_ok = start && door_closed && (r_guard == '0);

  // The highest-priority asserted event decides; if it has no arc here, hold
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (!clear && door_closed && !stop && !timer_done && w_start_ok)
          w_state_nxt = COOK;
      end
      COOK: begin
        if (clear)
          w_state_nxt = IDLE;
        else if (!door_closed || stop)
          w_state_nxt = PAUSE;
        else if (timer_done)
          w_state_nxt = DONE;
      end
      PAUSE: begin
        if (clear)
          w_state_nxt = IDLE;
        else if (door_closed) begin
          if (stop)
            w_state_nxt = IDLE;
          else if (!timer_done && w_start_ok)
            w_state_nxt = COOK;
        end
      end
      DONE: begin
        if (clear || !door_closed || stop)
          w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_guard <= '0;
    else if (r_state == COOK && w_state_nxt != COOK)
      r_guard <= GUARD_W'(GUARD_CYC);
    else if (r_guard != '0)
      r_guard <= r_guard - 1'b1;
  end

  // Power is latched only on a fresh start; resume from PAUSE keeps it
  assign w_load      = (r_state == IDLE) && (w_state_nxt == COOK);
  assign w_power_sel = w_load ? power_level : r_power_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_power_q <= '0;
    else if (w_load)
      r_power_q <= power_level;
  end

  mag_pwm #(
    .POWER_W (POWER_W)
  ) u_pwm (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (w_state_nxt == COOK),
    .hold    (r_state != COOK),
    .load    (w_load),
    .tick_en (tick_en),
    .power_q (w_power_sel),
    .mag_q   (w_mag_q)
  );

  assign mag_on = w_mag_q & door_closed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag_prev <= 1'b0;
      r_sr_set   <= 1'b0;
      r_sr_rst   <= 1'b0;
    end else begin
      r_mag_prev <= mag_on;
      r_sr_set   <= mag_on & ~r_mag_prev;
      r_sr_rst   <= ~mag_on & r_mag_prev;
    end
  end

  assign sr_set    = r_sr_set;
  assign sr_rst    = r_sr_rst;
  assign cook_done = (r_state == DONE);
  assign state_o   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_magnetron_ctrl.sv
// ============================================================================
// tb_magnetron_ctrl : directed and random checks of magnetron_ctrl against a table model
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_magnetron_ctrl;

  localparam int PW    = 3;
  localparam int GC    = 4;
  localparam int STEPS = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          clear = 1'b0;
  logic          door_closed = 1'b1;
  logic          timer_done = 1'b0;
  logic          tick_en = 1'b0;
  logic [PW-1:0] power_level = '0;
  logic          mag_on;
  logic          sr_set;
  logic          sr_rst;
  logic          cook_done;
  logic [1:0]    state_o;

  magnetron_ctrl #(
    .POWER_W   (PW),
    .GUARD_CYC (GC),
    .GUARD_W   (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .door_closed (door_closed),
    .timer_done  (timer_done),
    .tick_en     (tick_en),
    .power_level (power_level),
    .mag_on      (mag_on),
    .sr_set      (sr_set),
    .sr_rst      (sr_rst),
    .cook_done   (cook_done),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: 0 IDLE, 1 COOK, 2 PAUSE, 3 DONE
  int m_state, m_guard, m_cnt, m_pow, m_ramp;
  bit m_magq, m_prev, m_set, m_rst;

  // Next state indexed by [state][event]; events: clear, door open, stop, timer, start, none
  int nxt_tbl [4][6] = '{
    '{0, 0, 0, 0, 1, 0},
    '{0, 2, 2, 3, 1, 1},
    '{0, 2, 0, 2, 1, 2},
    '{0, 0, 0, 3, 3, 3}
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_guard = 0; m_cnt = 0; m_pow = 0; m_ramp = 0;
    m_magq = 0; m_prev = 0; m_set = 0; m_rst = 0;
  endtask

  task automatic model_edge(input bit s, p, c, d, t, k, input int pl);
    int evt, nxt, eff;
    bit mon;
    mon    = m_magq & d;
    m_set  = mon & !m_prev;
    m_rst  = !mon & m_prev;
    m_prev = mon;
    if (c)                      evt = 0;
    else if (!d)                evt = 1;
    else if (p)                 evt = 2;
    else if (t)                 evt = 3;
    else if (s && m_guard == 0) evt = 4;
    else                        evt = 5;
    nxt = nxt_tbl[m_state][evt];
    if (m_state == 1 && nxt != 1) m_guard = GC;
    else if (m_guard > 0)         m_guard--;
    if (m_state == 0 && nxt == 1) begin
      m_cnt = 0;
      m_pow = pl;
    end else if (m_state == 1 && k) begin
      m_cnt = (m_cnt + 1) % STEPS;
    end
    if (nxt != 1)                          m_ramp = 0;
    else if (m_state == 1 && k && m_ramp < STEPS) m_ramp++;
    eff = m_pow;
`ifdef SOFT_START_EN
    if (m_ramp < STEPS) eff = 0;
`endif
    m_magq  = (nxt == 1) && (m_cnt <= eff);
    m_state = nxt;
  endtask

  task automatic step(input bit s, p, c, d, t, k, input int pl);
    @(negedge clk);
    start = s; stop = p; clear = c; door_closed = d; timer_done = t; tick_en = k;
    power_level = PW'(pl);
    #1;
    check("state_o", 32'(state_o), 32'(m_state));
    check("mag_on", 32'(mag_on), 32'(m_magq & d));
    check("sr_set", 32'(sr_set), 32'(m_set));
    check("sr_rst", 32'(sr_rst), 32'(m_rst));
    check("cook_done", 32'(cook_done), 32'(m_state == 3));
    check("sr_exclusive", 32'(sr_set & sr_rst), 32'd0);
    model_edge(s, p, c, d, t, k, pl);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0, 0);
  endtask

  initial begin
    int on_cnt, set_cnt, rst_cnt;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_mag_on", 32'(mag_on), 32'd0);
    rst_n = 1'b1;

    // power 2 over two PWM periods
    step(1, 0, 0, 1, 0, 0, 2);
    on_cnt = 0; set_cnt = 0; rst_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, 0, 1, 5);
      check("cook_state", 32'(state_o), 32'd1);
      on_cnt  += int'(mag_on);
      set_cnt += int'(sr_set);
      rst_cnt += int'(sr_rst);
    end
    check("duty_p2", 32'(on_cnt), 32'd6);
    check("sr_set_cnt", 32'(set_cnt), 32'd2);
    check("sr_rst_cnt", 32'(rst_cnt), 32'd2);

    // door opens mid-COOK, guarded restart, resume
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("door_kill", 32'(mag_on), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 1, 0, 0, 7);
      check("guard_hold", 32'(state_o), 32'd2);
    end
    step(1, 0, 0, 1, 0, 0, 7);
    step(0, 0, 0, 1, 0, 1, 7);
    check("resume", 32'(state_o), 32'd1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 1, 7);

    // timer expiry then clear
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    check("done_flag", 32'(cook_done), 32'd1);
    step(0, 0, 1, 1, 0, 0, 0);
    idle_steps(5);

    // simultaneous events
    step(1, 1, 1, 1, 0, 0, 3);
    step(1, 1, 0, 1, 0, 0, 3);
    step(1, 0, 0, 1, 0, 0, 3);
    step(0, 0, 1, 1, 1, 1, 3);
    idle_steps(6);

    // full power, also covers soft-start ramp when enabled
    step(1, 0, 0, 1, 0, 0, 7);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, 0, 1, 0);
`ifdef SOFT_START_EN
      check("soft_duty", 32'(mag_on), (i < 8) ? 32'(i == 0) : 32'd1);
`else
      check("full_duty", 32'(mag_on), 32'd1);
`endif
    end

    // asynchronous reset while the magnetron is on
    check("pre_rst_on", 32'(mag_on), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mag_on", 32'(mag_on), 32'd0);
    check("arst_sr_set", 32'(sr_set), 32'd0);
    check("arst_sr_rst", 32'(sr_rst), 32'd0);
    check("arst_done", 32'(cook_done), 32'd0);
    check("arst_state", 32'(state_o), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 800; i++) begin
      step(($urandom % 3) == 0, ($urandom % 12) == 0, ($urandom % 20) == 0,
           ($urandom % 10) != 0, ($urandom % 14) == 0, ($urandom % 2) == 0,
           int'($urandom_range(0, STEPS - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
